// File: rtl/packet_gen.sv
// packet_gen: CSR-programmed Avalon-ST test packet transmitter.
// 64-bit beats, 8 symbols per beat, first byte in [63:56].
// Byte n of every packet is (SEED + n) mod 256. Packets of one START run
// back-to-back. The CSR port is Avalon-MM with a fixed one-cycle read latency.
module packet_gen #(
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        clk_i,
    input  logic        arst_n_i,

    output logic        csr_waitrequest_o,
    input  logic [1:0]  csr_address_i,
    input  logic        csr_write_i,
    input  logic [31:0] csr_writedata_i,
    input  logic        csr_read_i,
    output logic [31:0] csr_readdata_o,
    output logic        csr_readdatavalid_o,

    input  logic        ast_ready_i,
    output logic [63:0] ast_data_o,
    output logic        ast_valid_o,
    output logic        ast_startofpacket_o,
    output logic        ast_endofpacket_o,
    output logic [2:0]  ast_empty_o
);

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_LEN   = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;
    localparam logic [1:0] ADDR_SEED  = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [15:0] LEN_RESET   = 16'd64;
    localparam logic [15:0] COUNT_RESET = 16'd1;
    localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);

    // Programmable registers (software view)
    logic [15:0] len_q,   len_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  seed_q,  seed_d;
    logic        err_q,   err_d;
    logic [15:0] sent_q,  sent_d;

    // Snapshot taken at START; the transmitter only looks at these
    logic [15:0] snap_len_q,   snap_len_d;
    logic [15:0] snap_count_q, snap_count_d;
    logic [7:0]  snap_seed_q,  snap_seed_d;

    // Transmit state
    logic [0:0]  state_q, state_d;
    logic [7:0]  beat_q,  beat_d;

    // CSR read return path
    logic [31:0] rdata_q,  rdata_d;
    logic        rvalid_q, rvalid_d;

    // Derived transmit signals
    logic        sending;
    logic [12:0] words_m1;
    logic        last_beat;
    logic        final_pkt;
    logic        xfer;
    logic [63:0] beat_data;
    logic [15:0] byte_idx;
    logic [2:0]  empty_val;

    // START qualification
    logic        start_req;
    logic        len_ok;
    logic        count_ok;

    logic        unused_wdata;

    assign unused_wdata = ^csr_writedata_i[31:16];

    assign csr_waitrequest_o = 1'b0;

    assign sending   = (state_q == ST_SEND);
    // words - 1 == (LEN - 1) / 8, valid because a started LEN is never 0
    assign words_m1  = 13'((snap_len_q - 16'd1) >> 3);
    assign last_beat = ({5'd0, beat_q} == words_m1);
    assign final_pkt = (sent_q == (snap_count_q - 16'd1));
    assign xfer      = sending && ast_ready_i;
    assign empty_val = 3'd0 - snap_len_q[2:0];

    assign start_req = csr_write_i && (csr_address_i == ADDR_CTRL) && csr_writedata_i[0];
    assign len_ok    = (len_q != 16'd0) && (len_q <= MAX_LEN_W);
    assign count_ok  = (count_q != 16'd0);

    // Build the current beat from the pattern; lanes past LEN stay zero
    always_comb begin
        beat_data = '0;
        byte_idx  = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            byte_idx = {5'd0, beat_q, 3'd0} + 16'(j);
            if (byte_idx < snap_len_q) begin
                beat_data[63 - 8*j -: 8] = snap_seed_q + byte_idx[7:0];
            end
        end
    end

    // Source outputs are decoded from state so reset removes valid at once
    always_comb begin
        ast_valid_o         = sending;
        ast_data_o          = sending ? beat_data : '0;
        ast_startofpacket_o = sending && (beat_q == 8'd0);
        ast_endofpacket_o   = sending && last_beat;
        ast_empty_o         = (sending && last_beat) ? empty_val : '0;
    end

    assign csr_readdata_o      = rdata_q;
    assign csr_readdatavalid_o = rvalid_q;

    // CSR read mux: captures the pre-write value when read and write coincide
    always_comb begin
        rvalid_d = csr_read_i;
        rdata_d  = '0;
        if (csr_read_i) begin
            case (csr_address_i)
                ADDR_CTRL:  rdata_d = {sent_q, 14'd0, err_q, sending};
                ADDR_LEN:   rdata_d = {16'd0, len_q};
                ADDR_COUNT: rdata_d = {16'd0, count_q};
                ADDR_SEED:  rdata_d = {24'd0, seed_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    // Next-state: CSR writes, START acceptance and beat/packet sequencing
    always_comb begin
        len_d        = len_q;
        count_d      = count_q;
        seed_d       = seed_q;
        err_d        = err_q;
        sent_d       = sent_q;
        snap_len_d   = snap_len_q;
        snap_count_d = snap_count_q;
        snap_seed_d  = snap_seed_q;
        state_d      = state_q;
        beat_d       = beat_q;

        if (csr_write_i) begin
            case (csr_address_i)
                ADDR_CTRL: begin
                    if (csr_writedata_i[1]) begin
                        err_d = 1'b0;
                    end
                end
                ADDR_LEN: begin
                    if (!sending) len_d = csr_writedata_i[15:0];
                end
                ADDR_COUNT: begin
                    if (!sending) count_d = csr_writedata_i[15:0];
                end
                ADDR_SEED: begin
                    if (!sending) seed_d = csr_writedata_i[7:0];
                end
                default: ;
            endcase
        end

        // A rejected START sets ERR even if the same write also asks to clear it
        if (start_req && !sending) begin
            if (len_ok && count_ok) begin
                snap_len_d   = len_q;
                snap_count_d = count_q;
                snap_seed_d  = seed_q;
                sent_d       = '0;
                beat_d       = '0;
                state_d      = ST_SEND;
            end else begin
                err_d = 1'b1;
            end
        end

        if (xfer) begin
            if (last_beat) begin
                beat_d = '0;
                sent_d = sent_q + 16'd1;
                if (final_pkt) begin
                    state_d = ST_IDLE;
                end
            end else begin
                beat_d = beat_q + 8'd1;
            end
        end
    end

    // Register update with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            len_q        <= LEN_RESET;
            count_q      <= COUNT_RESET;
            seed_q       <= '0;
            err_q        <= 1'b0;
            sent_q       <= '0;
            snap_len_q   <= '0;
            snap_count_q <= '0;
            snap_seed_q  <= '0;
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            len_q        <= len_d;
            count_q      <= count_d;
            seed_q       <= seed_d;
            err_q        <= err_d;
            sent_q       <= sent_d;
            snap_len_q   <= snap_len_d;
            snap_count_q <= snap_count_d;
            snap_seed_q  <= snap_seed_d;
            state_q      <= state_d;
            beat_q       <= beat_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_packet_gen.sv
// Testbench for packet_gen: directed CSR sequences, a packet-level model that
// expands each accepted START into its expected beats, and one compare process
// that checks the stream every cycle.
`timescale 1ns/1ps
module tb_packet_gen;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        csr_waitrequest;
    logic [1:0]  csr_address = '0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        ast_ready = 1'b1;
    logic [63:0] ast_data;
    logic        ast_valid;
    logic        ast_sop;
    logic        ast_eop;
    logic [2:0]  ast_empty;

    packet_gen #(.MAX_LEN(1518)) dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .csr_waitrequest_o   (csr_waitrequest),
        .csr_address_i       (csr_address),
        .csr_write_i         (csr_write),
        .csr_writedata_i     (csr_writedata),
        .csr_read_i          (csr_read),
        .csr_readdata_o      (csr_readdata),
        .csr_readdatavalid_o (csr_readdatavalid),
        .ast_ready_i         (ast_ready),
        .ast_data_o          (ast_data),
        .ast_valid_o         (ast_valid),
        .ast_startofpacket_o (ast_sop),
        .ast_endofpacket_o   (ast_eop),
        .ast_empty_o         (ast_empty)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit tog     = 1'b0;

    typedef struct {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    beat_t       q[$];
    logic [63:0] cap_d[$];
    logic [2:0]  cap_e[$];

    // Software-visible model state
    logic [15:0] m_len   = 16'd64;
    logic [15:0] m_count = 16'd1;
    logic [7:0]  m_seed  = 8'd0;
    logic        m_err   = 1'b0;
    logic        m_busy  = 1'b0;
    logic [15:0] m_sent  = 16'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {m_sent, 14'd0, m_err, m_busy};
            2'd1:    return {16'd0, m_len};
            2'd2:    return {16'd0, m_count};
            default: return {24'd0, m_seed};
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_len = 16'd64; m_count = 16'd1; m_seed = 8'd0;
        m_err = 1'b0; m_busy = 1'b0; m_sent = 16'd0;
    endtask

    // Expand one START into every expected beat of every packet
    task automatic push_packets();
        int unsigned len, words, n;
        beat_t b;
        len   = int'(m_len);
        words = (len + 7) / 8;
        for (int p = 0; p < int'(m_count); p++) begin
            for (int unsigned k = 0; k < words; k++) begin
                b.d = '0;
                for (int unsigned j = 0; j < 8; j++) begin
                    n = 8 * k + j;
                    if (n < len) b.d[63 - 8*j -: 8] = 8'((int'(m_seed) + n) % 256);
                end
                b.sop   = (k == 0);
                b.eop   = (k == words - 1);
                b.empty = b.eop ? 3'((8 - len % 8) % 8) : 3'd0;
                q.push_back(b);
            end
        end
    endtask

    task automatic model_wr(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: begin
                if (d[1]) m_err = 1'b0;
                if (d[0] && !m_busy) begin
                    if (m_len >= 16'd1 && m_len <= 16'd1518 && m_count != 16'd0) begin
                        push_packets();
                        m_busy = 1'b1;
                        m_sent = 16'd0;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            2'd1: if (!m_busy) m_len = d[15:0];
            2'd2: if (!m_busy) m_count = d[15:0];
            default: if (!m_busy) m_seed = d[7:0];
        endcase
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        csr_address = a; csr_writedata = d; csr_write = 1'b1; csr_read = 1'b0;
        @(posedge clk); #1;
        csr_write = 1'b0;
        model_wr(a, d);
    endtask

    // Read with optional simultaneous write; exp is the required read data
    task automatic csr_acc(input logic [1:0] a, input bit do_wr, input logic [31:0] d,
                           input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        csr_address = a; csr_read = 1'b1; csr_write = do_wr; csr_writedata = d;
        @(posedge clk); #1;
        csr_read = 1'b0; csr_write = 1'b0;
        if (do_wr) model_wr(a, d);
        @(negedge clk);
        chk({name, "_rdv"}, 64'(csr_readdatavalid), 64'd1);
        chk(name, 64'(csr_readdata), 64'(exp));
        @(negedge clk);
        chk({name, "_rdv_pulse"}, 64'(csr_readdatavalid), 64'd0);
    endtask

    task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        csr_acc(a, 1'b0, 32'd0, exp, name);
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (q.size() == 0 && !m_busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s: timeout, %0d beats still expected", name, q.size());
        end
    endtask

    // Ready source: constant 1, or toggling every clock when tog is set
    initial begin
        forever begin
            @(posedge clk); #1;
            ast_ready = tog ? ~ast_ready : 1'b1;
        end
    end

    // Stream compare: valid must track the model, beats must match and hold
    always @(negedge clk) begin
        bit ev;
        if (arst_n) begin
            ev = (q.size() != 0);
            chk("valid", 64'(ast_valid), 64'(ev));
            if (ast_valid && ev) begin
                chk("data",  ast_data,         q[0].d);
                chk("sop",   64'(ast_sop),     64'(q[0].sop));
                chk("eop",   64'(ast_eop),     64'(q[0].eop));
                chk("empty", 64'(ast_empty),   64'(q[0].empty));
                if (ast_ready) begin
                    cap_d.push_back(ast_data);
                    cap_e.push_back(ast_empty);
                    if (q[0].eop) m_sent = m_sent + 16'd1;
                    void'(q.pop_front());
                    if (q.size() == 0) m_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3;
        chk("rst_valid", 64'(ast_valid), 64'd0);
        chk("rst_sop",   64'(ast_sop),   64'd0);
        chk("rst_eop",   64'(ast_eop),   64'd0);
        chk("rst_data",  ast_data,       64'd0);
        chk("rst_empty", 64'(ast_empty), 64'd0);
        chk("rst_rdv",   64'(csr_readdatavalid), 64'd0);
        chk("rst_rdata", 64'(csr_readdata), 64'd0);
        #19 arst_n = 1'b1;
        chk("waitreq", 64'(csr_waitrequest), 64'd0);
        csr_rd(2'd1, 32'h0000_0040, "rst_len");
        csr_rd(2'd2, 32'h0000_0001, "rst_count");
        csr_rd(2'd3, 32'h0000_0000, "rst_seed");
        csr_rd(2'd0, 32'h0000_0000, "rst_ctrl");

        // Single-beat packet
        csr_wr(2'd1, 32'd8);
        csr_wr(2'd3, 32'h10);
        cap_d.delete(); cap_e.delete();
        csr_wr(2'd0, 32'h1);
        wait_idle(50, "t1_idle");
        chk("t1_beats", 64'(cap_d.size()), 64'd1);
        chk("t1_data",  cap_d[0], 64'h1011121314151617);
        chk("t1_empty", 64'(cap_e[0]), 64'd0);
        csr_rd(2'd0, 32'h0001_0000, "t1_ctrl");

        // Two beats, seed wraps past 0xFF, partial last beat
        csr_wr(2'd1, 32'd13);
        csr_wr(2'd3, 32'hFE);
        cap_d.delete(); cap_e.delete();
        csr_wr(2'd0, 32'h1);
        wait_idle(50, "t2_idle");
        chk("t2_beats", 64'(cap_d.size()), 64'd2);
        chk("t2_data0", cap_d[0], 64'hFEFF000102030405);
        chk("t2_data1", cap_d[1], 64'h060708090A000000);
        chk("t2_empty", 64'(cap_e[1]), 64'd3);
        csr_rd(2'd1, 32'h0000_000D, "t2_len");

        // Three packets with ready toggling
        csr_wr(2'd2, 32'd3);
        csr_wr(2'd1, 32'd16);
        cap_d.delete(); cap_e.delete();
        tog = 1'b1;
        csr_wr(2'd0, 32'h1);
        wait_idle(100, "t3_idle");
        tog = 1'b0;
        chk("t3_beats", 64'(cap_d.size()), 64'd6);
        csr_rd(2'd0, 32'h0003_0000, "t3_ctrl");

        // Illegal START parameters set ERR, clear bit drops it
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd0, 32'h1);
        csr_rd(2'd0, 32'h0003_0002, "t4_err_len0");
        csr_wr(2'd0, 32'h2);
        csr_rd(2'd0, 32'h0003_0000, "t4_clr");
        csr_wr(2'd1, 32'd8);
        csr_wr(2'd2, 32'd0);
        csr_wr(2'd0, 32'h1);
        csr_rd(2'd0, 32'h0003_0002, "t4_err_cnt0");
        csr_wr(2'd0, 32'h2);
        csr_wr(2'd2, 32'd1);
        csr_wr(2'd1, 32'd1519);
        csr_wr(2'd0, 32'h1);
        csr_rd(2'd0, model_rd(2'd0), "t4_err_len1519");
        csr_wr(2'd0, 32'h2);
        csr_rd(2'd0, 32'h0003_0000, "t4_clr2");

        // One-byte packet
        csr_wr(2'd1, 32'd1);
        csr_wr(2'd3, 32'hAB);
        cap_d.delete(); cap_e.delete();
        csr_wr(2'd0, 32'h1);
        wait_idle(50, "t5_idle");
        chk("t5_data",  cap_d[0], 64'hAB00000000000000);
        chk("t5_empty", 64'(cap_e[0]), 64'd7);

        // Maximum length packet
        csr_wr(2'd1, 32'd1518);
        csr_wr(2'd3, 32'h00);
        cap_d.delete(); cap_e.delete();
        csr_wr(2'd0, 32'h1);
        wait_idle(400, "t6_idle");
        chk("t6_beats", 64'(cap_d.size()), 64'd190);
        chk("t6_last",  cap_d[189], 64'hE8E9EAEBECED0000);
        chk("t6_empty", 64'(cap_e[189]), 64'd2);

        // Writes and START while busy are ignored
        csr_wr(2'd1, 32'd24);
        csr_wr(2'd2, 32'd2);
        csr_wr(2'd3, 32'h30);
        cap_d.delete(); cap_e.delete();
        csr_wr(2'd0, 32'h1);
        csr_wr(2'd1, 32'd5);
        csr_wr(2'd0, 32'h1);
        wait_idle(100, "t7_idle");
        chk("t7_beats", 64'(cap_d.size()), 64'd6);
        csr_rd(2'd1, 32'h0000_0018, "t7_len");
        csr_rd(2'd0, model_rd(2'd0), "t7_ctrl");

        // Read and write in the same cycle return the old value
        csr_acc(2'd1, 1'b1, 32'h20, 32'h0000_0018, "t8_rw");
        csr_rd(2'd1, 32'h0000_0020, "t8_len");

        // Reset during beat 2 of a 5-beat packet
        csr_wr(2'd1, 32'd40);
        csr_wr(2'd2, 32'd1);
        csr_wr(2'd3, 32'h00);
        cap_d.delete(); cap_e.delete();
        csr_wr(2'd0, 32'h1);
        for (int i = 0; i < 50 && cap_d.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        chk("t9_reach", 64'(cap_d.size()), 64'd2);
        @(posedge clk); #2;
        chk("t9_pre_valid", 64'(ast_valid), 64'd1);
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("t9_valid", 64'(ast_valid), 64'd0);
        chk("t9_sop",   64'(ast_sop),   64'd0);
        chk("t9_eop",   64'(ast_eop),   64'd0);
        chk("t9_data",  ast_data,       64'd0);
        chk("t9_empty", 64'(ast_empty), 64'd0);
        repeat (2) @(negedge clk);
        #2 arst_n = 1'b1;
        csr_rd(2'd1, 32'h0000_0040, "t9_len");
        csr_rd(2'd2, 32'h0000_0001, "t9_count");
        csr_rd(2'd3, 32'h0000_0000, "t9_seed");
        csr_rd(2'd0, 32'h0000_0000, "t9_ctrl");
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
